// File: rtl/commit_id_dispatch_pkg.sv
// Shared constants for the issue side of the commit_id handshake.
// Branch indices and id width are used by both dispatch and commit.
package commit_id_dispatch_pkg;

    localparam int COMMIT_ID_WIDTH = 9;

    localparam int N_INSTR_BRANCHES  = 3;
    localparam int INSTR_BRANCH_ALU  = 0;
    localparam int INSTR_BRANCH_MAC  = 1;
    localparam int INSTR_BRANCH_LSU  = 2;

    localparam int BRANCH_WIDTH =
        (N_INSTR_BRANCHES > 1) ? $clog2(N_INSTR_BRANCHES) : 1;

    localparam int OP_WIDTH   = 5;
    localparam int DEST_WIDTH = 4;

    typedef logic [COMMIT_ID_WIDTH-1:0] commit_id_t;

    // Ids wrap, so distance is taken modulo 2**COMMIT_ID_WIDTH.
    function automatic commit_id_t cid_distance(
        input commit_id_t head,
        input commit_id_t tail
    );
        return head - tail;
    endfunction

endpackage

// File: rtl/commit_id_dispatch_slot.sv
// One-entry valid/ready holding register feeding one execution branch.
// A drain and a load in the same cycle keep the slot full with new data.
module dispatch_slot
    import commit_id_dispatch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/commit_id_dispatch.sv
// Tags decoded instructions with sequential commit ids and routes them
// to per-branch output slots, throttled by the commit window.
module commit_id_dispatch
    import commit_id_dispatch_pkg::*;
#(
    parameter int data_width   = 16,
    parameter int n_blocks     = 256,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BRANCH_WIDTH-1:0]       in_branch,
    input  logic [$clog2(n_blocks)-1:0]   in_block,
    input  logic [OP_WIDTH-1:0]           in_op,
    input  logic [data_width-1:0]         in_a,
    input  logic [data_width-1:0]         in_b,
    input  logic [DEST_WIDTH-1:0]         in_dest,
    input  logic                          in_flag,
    input  logic [COMMIT_ID_WIDTH-1:0]    next_commit_id,
    output logic [N_INSTR_BRANCHES-1:0]   out_valid,
    input  logic [N_INSTR_BRANCHES-1:0]   out_ready,
    output logic [$clog2(n_blocks)-1:0]   out_block     [N_INSTR_BRANCHES],
    output logic [OP_WIDTH-1:0]           out_op        [N_INSTR_BRANCHES],
    output logic [data_width-1:0]         out_a         [N_INSTR_BRANCHES],
    output logic [data_width-1:0]         out_b         [N_INSTR_BRANCHES],
    output logic [DEST_WIDTH-1:0]         out_dest      [N_INSTR_BRANCHES],
    output logic                          out_flag      [N_INSTR_BRANCHES],
    output logic [COMMIT_ID_WIDTH-1:0]    out_commit_id [N_INSTR_BRANCHES],
    output logic                          idle,
    output logic                          bad_branch
);

    localparam int BLK_W = $clog2(n_blocks);
    localparam int PAY_W = COMMIT_ID_WIDTH + BLK_W + OP_WIDTH
                         + 2 * data_width + DEST_WIDTH + 1;
    localparam int PAD_N = 2 ** BRANCH_WIDTH;

    localparam logic [COMMIT_ID_WIDTH:0] MAX_W =
        (COMMIT_ID_WIDTH + 1)'(MAX_INFLIGHT);
    localparam logic [BRANCH_WIDTH:0] N_BR =
        (BRANCH_WIDTH + 1)'(N_INSTR_BRANCHES);

    commit_id_t issue_id_q;
    commit_id_t issue_id_d;
    commit_id_t in_flight;
    logic       bad_branch_q;
    logic       bad_branch_d;

    logic             in_range;
    logic             window_open;
    logic             slot_free;
    logic             accept;
    logic [PAD_N-1:0] valid_pad;
    logic [PAD_N-1:0] ready_pad;
    logic [PAY_W-1:0] in_payload;

    logic [N_INSTR_BRANCHES-1:0] load;
    logic [PAY_W-1:0]            slot_payload [N_INSTR_BRANCHES];

    always_comb begin
        in_flight   = cid_distance(issue_id_q, next_commit_id);
        window_open = ({1'b0, in_flight} < MAX_W);
        in_range    = ({1'b0, in_branch} < N_BR);

        // Padded copies let an out-of-range index be looked up safely.
        valid_pad = '0;
        ready_pad = '0;
        valid_pad[N_INSTR_BRANCHES-1:0] = out_valid;
        ready_pad[N_INSTR_BRANCHES-1:0] = out_ready;

        slot_free = !in_range
                  || !valid_pad[in_branch]
                  || ready_pad[in_branch];
        in_ready  = enable && window_open && slot_free;
        accept    = in_valid && in_ready;

        issue_id_d = issue_id_q;
        if (accept && in_range) begin
            issue_id_d = issue_id_q + 1'b1;
        end

        // Dropped instructions burn no id, so commit never waits on them.
        bad_branch_d = bad_branch_q || (accept && !in_range);

        in_payload = {issue_id_q, in_block, in_op,
                      in_a, in_b, in_dest, in_flag};
    end

    for (genvar k = 0; k < N_INSTR_BRANCHES; k++) begin : g_slot
        assign load[k] = accept && in_range
                       && (in_branch == BRANCH_WIDTH'(k));

        dispatch_slot #(
            .W (PAY_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .drain     (out_ready[k]),
            .load_data (in_payload),
            .valid     (out_valid[k]),
            .data      (slot_payload[k])
        );

        assign {out_commit_id[k], out_block[k], out_op[k],
                out_a[k], out_b[k], out_dest[k],
                out_flag[k]} = slot_payload[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_id_q   <= '0;
            bad_branch_q <= 1'b0;
        end else begin
            issue_id_q   <= issue_id_d;
            bad_branch_q <= bad_branch_d;
        end
    end

    assign bad_branch = bad_branch_q;
    assign idle       = (out_valid == '0)
                     && (issue_id_q == next_commit_id);

endmodule

// File: tb/tb_commit_id_dispatch.sv
// Directed and random checks of commit_id_dispatch against a
// behavioural model of the id window and per-branch slots.
module tb_commit_id_dispatch;
    import commit_id_dispatch_pkg::*;

    localparam int DW   = 16;
    localparam int NB   = 256;
    localparam int MAXI = 4;
    localparam int NBR  = N_INSTR_BRANCHES;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    in_valid;
    logic                    in_ready;
    logic [BRANCH_WIDTH-1:0] in_branch;
    logic [7:0]              in_block;
    logic [OP_WIDTH-1:0]     in_op;
    logic [DW-1:0]           in_a;
    logic [DW-1:0]           in_b;
    logic [DEST_WIDTH-1:0]   in_dest;
    logic                    in_flag;
    logic [8:0]              nci;
    logic [NBR-1:0]          out_valid;
    logic [NBR-1:0]          out_ready;
    logic [7:0]              out_block     [NBR];
    logic [OP_WIDTH-1:0]     out_op        [NBR];
    logic [DW-1:0]           out_a         [NBR];
    logic [DW-1:0]           out_b         [NBR];
    logic [DEST_WIDTH-1:0]   out_dest      [NBR];
    logic                    out_flag      [NBR];
    logic [8:0]              out_commit_id [NBR];
    logic                    idle;
    logic                    bad_branch;

    int errors = 0;
    int checks = 0;

    // Reference state: next id, slot contents, sticky error.
    int m_issue;
    bit m_valid [NBR];
    int m_cid   [NBR];
    int m_blk   [NBR];
    int m_op    [NBR];
    int m_a     [NBR];
    int m_b     [NBR];
    int m_dest  [NBR];
    int m_flag  [NBR];
    bit m_bad;

    always #5 clk = ~clk;

    commit_id_dispatch #(
        .data_width   (DW),
        .n_blocks     (NB),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_branch      (in_branch),
        .in_block       (in_block),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_dest        (in_dest),
        .in_flag        (in_flag),
        .next_commit_id (nci),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_block      (out_block),
        .out_op         (out_op),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_dest       (out_dest),
        .out_flag       (out_flag),
        .out_commit_id  (out_commit_id),
        .idle           (idle),
        .bad_branch     (bad_branch)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_inflight();
        return (m_issue - int'(nci) + 512) % 512;
    endfunction

    function automatic bit m_ready();
        int br;
        br = int'(in_branch);
        if (!enable) return 1'b0;
        if (m_inflight() >= MAXI) return 1'b0;
        if (br < NBR && m_valid[br] && !out_ready[br]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_clear();
        m_issue = 0;
        m_bad   = 1'b0;
        for (int k = 0; k < NBR; k++) begin
            m_valid[k] = 1'b0;
            m_cid[k] = 0; m_blk[k] = 0; m_op[k] = 0;
            m_a[k] = 0; m_b[k] = 0; m_dest[k] = 0; m_flag[k] = 0;
        end
    endtask

    task automatic check_outputs();
        bit all_empty;
        all_empty = 1'b1;
        for (int k = 0; k < NBR; k++) begin
            chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(m_valid[k]));
            chk($sformatf("cid%0d", k), 32'(out_commit_id[k]), m_cid[k]);
            chk($sformatf("blk%0d", k), 32'(out_block[k]), m_blk[k]);
            chk($sformatf("op%0d", k), 32'(out_op[k]), m_op[k]);
            chk($sformatf("a%0d", k), 32'(out_a[k]), m_a[k]);
            chk($sformatf("b%0d", k), 32'(out_b[k]), m_b[k]);
            chk($sformatf("dest%0d", k), 32'(out_dest[k]), m_dest[k]);
            chk($sformatf("flag%0d", k), 32'(out_flag[k]), m_flag[k]);
            if (m_valid[k]) all_empty = 1'b0;
        end
        chk("bad_branch", 32'(bad_branch), 32'(m_bad));
        chk("idle", 32'(idle),
            32'(all_empty && (m_issue == int'(nci))));
    endtask

    // One clock: check in_ready, advance model, check registered outputs.
    task automatic step();
        bit acc;
        int br;
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        acc = in_valid && m_ready();
        br  = int'(in_branch);
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            for (int k = 0; k < NBR; k++)
                if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
            if (acc && br < NBR) begin
                m_valid[br] = 1'b1;
                m_cid[br]  = m_issue;
                m_blk[br]  = int'(in_block);
                m_op[br]   = int'(in_op);
                m_a[br]    = int'(in_a);
                m_b[br]    = int'(in_b);
                m_dest[br] = int'(in_dest);
                m_flag[br] = int'(in_flag);
                m_issue    = (m_issue + 1) % 512;
            end else if (acc) begin
                m_bad = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic put(input bit v, input int br);
        in_valid  = v;
        in_branch = BRANCH_WIDTH'(br);
        in_block  = 8'($urandom);
        in_op     = OP_WIDTH'($urandom);
        in_a      = DW'($urandom);
        in_b      = DW'($urandom);
        in_dest   = DEST_WIDTH'($urandom);
        in_flag   = 1'($urandom);
    endtask

    initial begin
        int saved_id;
        logic [DW-1:0] saved_a;
        m_clear();
        reset     = 1'b1;
        enable    = 1'b0;
        nci       = '0;
        out_ready = '0;
        put(1'b0, 0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // Three instructions, branches 0,1,0.
        enable    = 1'b1;
        out_ready = '1;
        put(1'b1, 0); step();
        chk("seq_id0", 32'(out_commit_id[0]), 32'd0);
        put(1'b1, 1); step();
        chk("seq_id1", 32'(out_commit_id[1]), 32'd1);
        put(1'b1, 0); step();
        chk("seq_id2", 32'(out_commit_id[0]), 32'd2);

        // Window of four with next_commit_id held at 0.
        reset = 1'b1; put(1'b0, 0); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, i % NBR);
            step();
        end
        put(1'b1, 2);
        #1;
        chk("win_full", 32'(in_ready), 32'd0);
        step();
        nci = 9'd1;
        #1;
        chk("win_reopen", 32'(in_ready), 32'd1);
        step();
        chk("win_id4", 32'(out_commit_id[2]), 32'd4);

        // Walk the id counter up to 510, then issue across the wrap.
        while (m_issue != 510) begin
            nci = 9'((m_issue + 511) % 512);
            put(1'b1, int'($urandom_range(0, NBR - 1)));
            step();
        end
        nci = 9'd509;
        put(1'b1, 0); step();
        chk("wrap_510", 32'(out_commit_id[0]), 32'd510);
        put(1'b1, 1); step();
        chk("wrap_511", 32'(out_commit_id[1]), 32'd511);
        put(1'b1, 2); step();
        chk("wrap_0", 32'(out_commit_id[2]), 32'd0);
        put(1'b1, 0);
        #1;
        chk("wrap_window", 32'(in_ready), 32'd0);

        // Back-pressure on branch 1, then same-cycle drain and refill.
        put(1'b0, 0);
        nci = 9'(m_issue);
        step();
        out_ready = 3'b101;
        put(1'b1, 1); step();
        saved_a  = out_a[1];
        saved_id = int'(out_commit_id[1]);
        put(1'b1, 1);
        for (int i = 0; i < 3; i++) step();
        chk("bp_stable", 32'(out_a[1]), 32'(saved_a));
        out_ready = '1;
        step();
        chk("bp_refill_id", 32'(out_commit_id[1]), 32'((saved_id + 1) % 512));
        chk("bp_refill_v", 32'(out_valid[1]), 32'd1);

        // Out-of-range branch is consumed without burning an id.
        put(1'b0, 0);
        nci = 9'(m_issue);
        step();
        saved_id = m_issue;
        put(1'b1, NBR); step();
        chk("bad_set", 32'(bad_branch), 32'd1);
        chk("bad_no_valid", 32'(out_valid), 32'd0);
        put(1'b1, 0); step();
        chk("bad_no_burn", 32'(out_commit_id[0]), 32'(saved_id));

        // Random traffic with a commit stage that trails the issue point.
        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = NBR'($urandom);
            put(1'($urandom), int'($urandom_range(0, NBR)));
            if ($urandom_range(0, 1) == 1)
                nci = 9'((int'(nci)
                      + int'($urandom_range(0, m_inflight()))) % 512);
            step();
        end

        // Reset with two slots held and five ids in flight.
        enable = 1'b1;
        put(1'b0, 0);
        out_ready = '1;
        nci = 9'(m_issue);
        step();
        out_ready = '0;
        put(1'b1, 0); step();
        put(1'b1, 1); step();
        put(1'b0, 0);
        nci = 9'((m_issue + 512 - 5) % 512);
        step();
        chk("pre_reset_v", 32'(out_valid), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        nci = '0;
        #1;
        chk("rst_idle", 32'(idle), 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
